proc_dpath_simd_alu: RTL and testbench

PROC_DPATH_SIMD_ALU -- requirements
Module: proc_dpath_simd_alu

---
 rtl/proc_simd_alu_pkg.sv | 63 ++++++
 rtl/proc_dpath_simd_addsub.sv | 79 +++++++
 rtl/proc_dpath_simd_alu.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_proc_dpath_simd_alu.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_simd_alu_pkg.sv
// ----------------------------------------------------------------------------
// proc_simd_alu_pkg
// Shared definitions for the SIMD ALU datapath:
//   - alu_op_e     : operation encoding carried on req_op
//   - lane_width_e : lane-width encoding carried on req_lw
//   - alu_state_e  : control FSM states
//   - lw_bits()    : lane-width code -> lane width in bits
//   - lane_mask()  : lane-width code -> byte-index mask that maps any byte
//                    of a lane onto its lane-end byte (idx | mask) or its
//                    lane-start byte (idx & ~mask)
// ----------------------------------------------------------------------------
package proc_simd_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_ADDS = 4'd2,
    OP_ADDU = 4'd3,
    OP_SUBS = 4'd4,
    OP_SUBU = 4'd5,
    OP_MIN  = 4'd6,
    OP_MAX  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MUL  = 4'd11
  } alu_op_e;

  // Code 3 is accepted and behaves exactly like 32-bit lanes.
  typedef enum logic [1:0] {
    LW_8   = 2'd0,
    LW_16  = 2'd1,
    LW_32  = 2'd2,
    LW_32X = 2'd3
  } lane_width_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic [5:0] lw_bits(input logic [1:0] lw);
    logic [5:0] bits;
    case (lw)
      LW_8:    bits = 6'd8;
      LW_16:   bits = 6'd16;
      default: bits = 6'd32;
    endcase
    return bits;
  endfunction

  function automatic logic [2:0] lane_mask(input logic [1:0] lw);
    logic [2:0] mask;
    case (lw)
      LW_8:    mask = 3'd0;
      LW_16:   mask = 3'd1;
      default: mask = 3'd3;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/proc_dpath_simd_addsub.sv
// ----------------------------------------------------------------------------
// proc_dpath_simd_addsub
// Combinational lane-partitioned adder/subtractor. The carry chain runs byte
// by byte and is killed (re-seeded with the subtract carry-in) at every lane
// start, so no carry or borrow crosses a lane boundary.
// Ports:
//   a_i, b_i  : operands (result = a + b, or a - b when sub_i = 1)
//   sub_i     : 1 = subtract
//   lw_i      : lane-width code
//   sum_o     : lane-wise wrapped result
//   ovf_s_o   : per-byte signed overflow of the owning lane
//   oor_u_o   : per-byte unsigned out-of-range (carry on add, borrow on sub)
//   lt_s_o    : per-byte signed a < b of the owning lane (valid when sub_i)
// ----------------------------------------------------------------------------
module proc_dpath_simd_addsub
  import proc_simd_alu_pkg::*;
#(
  parameter int P_NBITS = 32
) (
  input  logic [P_NBITS-1:0]   a_i,
  input  logic [P_NBITS-1:0]   b_i,
  input  logic                 sub_i,
  input  logic [1:0]           lw_i,
  output logic [P_NBITS-1:0]   sum_o,
  output logic [P_NBITS/8-1:0] ovf_s_o,
  output logic [P_NBITS/8-1:0] oor_u_o,
  output logic [P_NBITS/8-1:0] lt_s_o
);

  localparam int NB = P_NBITS / 8;

  // Flags as computed at every byte; only lane-end bytes carry meaning.
  logic [NB-1:0] end_ovf_s;
  logic [NB-1:0] end_oor_s;
  logic [NB-1:0] end_lt_s;

  // Byte-sliced ripple add with carry-kill at lane starts.
  always_comb begin
    logic       c;
    logic [7:0] bb;
    logic [8:0] bsum;
    logic [2:0] m;
    c         = 1'b0;
    bb        = 8'h00;
    bsum      = 9'h000;
    m         = lane_mask(lw_i);
    sum_o     = '0;
    end_ovf_s = '0;
    end_oor_s = '0;
    end_lt_s  = '0;
    for (int i = 0; i < NB; i++) begin
      bb = sub_i ? ~b_i[8*i +: 8] : b_i[8*i +: 8];
      // A lane start re-seeds the chain: 0 for add, 1 for the two's-complement +1.
      c = ((i & int'(m)) == 0) ? sub_i : c;
      bsum = {1'b0, a_i[8*i +: 8]} + {1'b0, bb} + {8'h00, c};
      sum_o[8*i +: 8] = bsum[7:0];
      c = bsum[8];
      end_ovf_s[i] = (a_i[8*i+7] == bb[7]) && (bsum[7] != a_i[8*i+7]);
      end_oor_s[i] = sub_i ? ~bsum[8] : bsum[8];
      end_lt_s[i]  = bsum[7] ^ end_ovf_s[i];
    end
  end

  // Broadcast each lane-end flag to every byte of its lane.
  always_comb begin
    int e;
    e       = 0;
    ovf_s_o = '0;
    oor_u_o = '0;
    lt_s_o  = '0;
    for (int i = 0; i < NB; i++) begin
      e = i | int'(lane_mask(lw_i));
      ovf_s_o[i] = end_ovf_s[e];
      oor_u_o[i] = end_oor_s[e];
      lt_s_o[i]  = end_lt_s[e];
    end
  end

endmodule

// File: rtl/proc_dpath_simd_alu.sv
// ----------------------------------------------------------------------------
// proc_dpath_simd_alu
// Valid/ready SIMD ALU with 8/16/32-bit lanes. Single-cycle ops produce a
// response the cycle after accept; MUL iterates one multiplier bit per cycle
// in every lane at once and responds LW+1 cycles after accept.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   req_val/req_rdy       : request handshake
//   req_op, req_lw        : operation and lane-width codes
//   req_in0, req_in1      : operands
//   resp_val/resp_rdy     : response handshake
//   resp_out              : result
//   resp_sat              : per-byte saturation flags
// ----------------------------------------------------------------------------
module proc_dpath_simd_alu
  import proc_simd_alu_pkg::*;
#(
  parameter int P_NBITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [3:0]           req_op,
  input  logic [1:0]           req_lw,
  input  logic [P_NBITS-1:0]   req_in0,
  input  logic [P_NBITS-1:0]   req_in1,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [P_NBITS-1:0]   resp_out,
  output logic [P_NBITS/8-1:0] resp_sat
);

  localparam int NB = P_NBITS / 8;

  alu_state_e         state_q, state_d;
  logic [1:0]         lw_q, lw_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [P_NBITS-1:0] mcand_q, mcand_d;
  logic [P_NBITS-1:0] mplier_q, mplier_d;
  logic [P_NBITS-1:0] acc_q, acc_d;
  logic [P_NBITS-1:0] out_q, out_d;
  logic [NB-1:0]      sat_q, sat_d;

  logic               accept_s;
  logic               req_rdy_s;
  logic [P_NBITS-1:0] as_a_s, as_b_s, as_sum_s;
  logic               as_sub_s;
  logic [1:0]         as_lw_s;
  logic [NB-1:0]      as_ovf_s, as_oor_s, as_lt_s;
  logic [P_NBITS-1:0] shl_s, shr_s, sra_s;
  logic [P_NBITS-1:0] res_s;
  logic [NB-1:0]      res_sat_s;
  logic [P_NBITS-1:0] addend_s, mcand_shl_s, mplier_shr_s;

  assign req_rdy_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && resp_rdy);
  assign accept_s  = req_val && req_rdy_s;
  assign req_rdy   = req_rdy_s;
  assign resp_val  = (state_q == ST_DONE);
  assign resp_out  = out_q;
  assign resp_sat  = sat_q;

  // The shared adder serves the MUL accumulator while iterating (no request
  // can be accepted then) and the incoming request otherwise.
  always_comb begin
    if (state_q == ST_MUL) begin
      as_a_s   = acc_q;
      as_b_s   = addend_s;
      as_sub_s = 1'b0;
      as_lw_s  = lw_q;
    end else begin
      as_a_s   = req_in0;
      as_b_s   = req_in1;
      as_sub_s = req_op inside {OP_SUB, OP_SUBS, OP_SUBU, OP_MIN, OP_MAX};
      as_lw_s  = req_lw;
    end
  end

  proc_dpath_simd_addsub #(
    .P_NBITS (P_NBITS)
  ) u_addsub (
    .a_i     (as_a_s),
    .b_i     (as_b_s),
    .sub_i   (as_sub_s),
    .lw_i    (as_lw_s),
    .sum_o   (as_sum_s),
    .ovf_s_o (as_ovf_s),
    .oor_u_o (as_oor_s),
    .lt_s_o  (as_lt_s)
  );

  // Per-lane shifters; the amount is the low log2(LW) bits of the in1 lane.
  always_comb begin
    shl_s = '0;
    shr_s = '0;
    sra_s = '0;
    case (req_lw)
      LW_8: begin
        for (int l = 0; l < NB; l++) begin
          shl_s[8*l +: 8] = req_in0[8*l +: 8] << req_in1[8*l +: 3];
          shr_s[8*l +: 8] = req_in0[8*l +: 8] >> req_in1[8*l +: 3];
          sra_s[8*l +: 8] = $signed(req_in0[8*l +: 8]) >>> req_in1[8*l +: 3];
        end
      end
      LW_16: begin
        for (int l = 0; l < NB/2; l++) begin
          shl_s[16*l +: 16] = req_in0[16*l +: 16] << req_in1[16*l +: 4];
          shr_s[16*l +: 16] = req_in0[16*l +: 16] >> req_in1[16*l +: 4];
          sra_s[16*l +: 16] = $signed(req_in0[16*l +: 16]) >>> req_in1[16*l +: 4];
        end
      end
      default: begin
        for (int l = 0; l < NB/4; l++) begin
          shl_s[32*l +: 32] = req_in0[32*l +: 32] << req_in1[32*l +: 5];
          shr_s[32*l +: 32] = req_in0[32*l +: 32] >> req_in1[32*l +: 5];
          sra_s[32*l +: 32] = $signed(req_in0[32*l +: 32]) >>> req_in1[32*l +: 5];
        end
      end
    endcase
  end

  // Single-cycle result selection, including clamping and sat flags.
  always_comb begin
    int         e;
    logic       neg;
    logic [2:0] m;
    e         = 0;
    neg       = 1'b0;
    m         = lane_mask(req_lw);
    res_s     = '0;
    res_sat_s = '0;
    case (req_op)
      OP_ADD, OP_SUB: res_s = as_sum_s;
      OP_ADDS, OP_SUBS: begin
        for (int i = 0; i < NB; i++) begin
          e   = i | int'(m);
          // On signed overflow the true result has the sign of in0.
          neg = req_in0[8*e+7];
          if (!as_ovf_s[i]) begin
            res_s[8*i +: 8] = as_sum_s[8*i +: 8];
          end else if (e == i) begin
            res_s[8*i +: 8] = neg ? 8'h80 : 8'h7F;
          end else begin
            res_s[8*i +: 8] = neg ? 8'h00 : 8'hFF;
          end
        end
        res_sat_s = as_ovf_s;
      end
      OP_ADDU: begin
        for (int i = 0; i < NB; i++) begin
          res_s[8*i +: 8] = as_oor_s[i] ? 8'hFF : as_sum_s[8*i +: 8];
        end
        res_sat_s = as_oor_s;
      end
      OP_SUBU: begin
        for (int i = 0; i < NB; i++) begin
          res_s[8*i +: 8] = as_oor_s[i] ? 8'h00 : as_sum_s[8*i +: 8];
        end
        res_sat_s = as_oor_s;
      end
      OP_MIN: begin
        for (int i = 0; i < NB; i++) begin
          res_s[8*i +: 8] = as_lt_s[i] ? req_in0[8*i +: 8] : req_in1[8*i +: 8];
        end
      end
      OP_MAX: begin
        for (int i = 0; i < NB; i++) begin
          res_s[8*i +: 8] = as_lt_s[i] ? req_in1[8*i +: 8] : req_in0[8*i +: 8];
        end
      end
      OP_SLL:  res_s = shl_s;
      OP_SRL:  res_s = shr_s;
      OP_SRA:  res_s = sra_s;
      default: begin
        // MUL is produced by the iteration; reserved codes return zero.
        res_s     = '0;
        res_sat_s = '0;
      end
    endcase
  end

  // MUL step: add the multiplicand lane when the multiplier lane LSB is set,
  // then shift multiplicand left / multiplier right within each lane.
  always_comb begin
    int         s;
    logic [2:0] mm;
    s            = 0;
    mm           = lane_mask(lw_q);
    addend_s     = '0;
    mcand_shl_s  = mcand_q << 1;
    mplier_shr_s = mplier_q >> 1;
    for (int i = 0; i < NB; i++) begin
      s = i & ~int'(mm);
      addend_s[8*i +: 8]  = mplier_q[8*s] ? mcand_q[8*i +: 8] : 8'h00;
      mcand_shl_s[8*i]    = (s == i) ? 1'b0 : mcand_shl_s[8*i];
      mplier_shr_s[8*i+7] = ((i | int'(mm)) == i) ? 1'b0 : mplier_shr_s[8*i+7];
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    lw_d     = lw_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    out_d    = out_q;
    sat_d    = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          lw_d     = req_lw;
          mcand_d  = req_in0;
          mplier_d = req_in1;
          acc_d    = '0;
          cnt_d    = 6'd0;
          if (req_op == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            state_d = ST_DONE;
            out_d   = res_s;
            sat_d   = res_sat_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d    = as_sum_s;
        mcand_d  = mcand_shl_s;
        mplier_d = mplier_shr_s;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == (lw_bits(lw_q) - 6'd1)) begin
          state_d = ST_DONE;
          out_d   = as_sum_s;
          sat_d   = '0;
          cnt_d   = 6'd0;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DONE: begin
        // Retire and accept in the same cycle: the new op starts with no bubble.
        if (accept_s) begin
          lw_d     = req_lw;
          mcand_d  = req_in0;
          mplier_d = req_in1;
          acc_d    = '0;
          cnt_d    = 6'd0;
          if (req_op == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            state_d = ST_DONE;
            out_d   = res_s;
            sat_d   = res_sat_s;
          end
        end else if (resp_rdy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      lw_q     <= 2'd0;
      cnt_q    <= 6'd0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      sat_q    <= '0;
    end else begin
      state_q  <= state_d;
      lw_q     <= lw_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: tb/tb_proc_dpath_simd_alu.sv
// ----------------------------------------------------------------------------
// tb_proc_dpath_simd_alu
// Directed vectors for proc_dpath_simd_alu (32-bit datapath). A lane-level
// arithmetic model predicts every response and its due cycle; one compare
// process checks resp_val/req_rdy/resp_out/resp_sat on every falling edge.
// Hand-computed literals pin the model on selected vectors.
// ----------------------------------------------------------------------------
module tb_proc_dpath_simd_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_val = 1'b0;
  logic        req_rdy;
  logic [3:0]  req_op = 4'd0;
  logic [1:0]  req_lw = 2'd0;
  logic [31:0] req_in0 = 32'd0;
  logic [31:0] req_in1 = 32'd0;
  logic        resp_val;
  logic        resp_rdy = 1'b1;
  logic [31:0] resp_out;
  logic [3:0]  resp_sat;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  sat;
    int          due;
  } exp_t;

  exp_t sb[$];

  proc_dpath_simd_alu #(.P_NBITS(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_op   (req_op),
    .req_lw   (req_lw),
    .req_in0  (req_in0),
    .req_in1  (req_in1),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_out (resp_out),
    .resp_sat (resp_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lane_w(input logic [1:0] lw);
    return (lw == 2'd0) ? 8 : (lw == 2'd1) ? 16 : 32;
  endfunction

  // Lane-by-lane arithmetic from the operation definitions.
  function automatic void model(input logic [3:0] op, input logic [1:0] lw,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] s);
    int w;
    longint unsigned x, y, m, v;
    longint sx, sy, sv, hi, lo;
    bit st;
    w  = lane_w(lw);
    r  = 32'd0;
    s  = 4'd0;
    m  = (64'd1 << w) - 64'd1;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    for (int l = 0; l < 32 / w; l++) begin
      x  = (64'(a) >> (l * w)) & m;
      y  = (64'(b) >> (l * w)) & m;
      sx = (x > (m >> 1)) ? longint'(x) - longint'(m) - 1 : longint'(x);
      sy = (y > (m >> 1)) ? longint'(y) - longint'(m) - 1 : longint'(y);
      st = 1'b0;
      v  = 64'd0;
      sv = 0;
      case (op)
        4'd0: v = x + y;
        4'd1: v = x - y;
        4'd2, 4'd4: begin
          sv = (op == 4'd2) ? sx + sy : sx - sy;
          if (sv > hi) begin sv = hi; st = 1'b1; end
          else if (sv < lo) begin sv = lo; st = 1'b1; end
          v = $unsigned(sv);
        end
        4'd3: begin
          v = x + y;
          if (v > m) begin v = m; st = 1'b1; end
        end
        4'd5: begin
          if (y > x) begin v = 64'd0; st = 1'b1; end
          else v = x - y;
        end
        4'd6:  v = (sx < sy) ? x : y;
        4'd7:  v = (sx > sy) ? x : y;
        4'd8:  v = x << (y % w);
        4'd9:  v = x >> (y % w);
        4'd10: v = $unsigned(sx >>> (y % w));
        4'd11: v = x * y;
        default: v = 64'd0;
      endcase
      v = v & m;
      r = r | 32'(v << (l * w));
      if (st) s = s | 4'(((1 << (w / 8)) - 1) << (l * (w / 8)));
    end
  endfunction

  // Compare process: predicts and checks outputs every cycle.
  always @(negedge clk) begin : compare
    logic exp_v;
    logic exp_rdy;
    exp_t e;
    if (!reset) begin
      sb.delete();
      chk("rst_resp_val", resp_val, 64'd0);
      chk("rst_req_rdy", req_rdy, 64'd1);
      chk("rst_resp_out", resp_out, 64'd0);
      chk("rst_resp_sat", resp_sat, 64'd0);
    end else begin
      exp_v = (sb.size() > 0) && (cyc >= sb[0].due);
      chk("resp_val", resp_val, exp_v);
      if (exp_v) begin
        chk("resp_out", resp_out, sb[0].res);
        chk("resp_sat", resp_sat, sb[0].sat);
      end
      exp_rdy = (sb.size() == 0) || (exp_v && resp_rdy);
      chk("req_rdy", req_rdy, exp_rdy);
      if (exp_v && resp_rdy) void'(sb.pop_front());
      if (req_val && exp_rdy) begin
        model(req_op, req_lw, req_in0, req_in1, e.res, e.sat);
        e.due = cyc + ((req_op == 4'd11) ? lane_w(req_lw) + 1 : 1);
        sb.push_back(e);
      end
    end
  end

  // Present a request from just after a rising edge until accepted; then
  // scramble the request inputs so in-flight work must not depend on them.
  task automatic send(input logic [3:0] op, input logic [1:0] lw,
                      input logic [31:0] a, input logic [31:0] b, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    req_op  = op;
    req_lw  = lw;
    req_in0 = a;
    req_in1 = b;
    req_val = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok  = req_rdy;
      acc = cyc;
      @(posedge clk);
      #1;
    end
    req_val = 1'b0;
    req_op  = op ^ 4'h3;
    req_lw  = ~lw;
    req_in0 = ~a;
    req_in1 = b ^ 32'h5A5A_5A5A;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: req_rdy stayed 0, expected 1 within 100 cycles");
    end
  endtask

  task automatic wait_resp(output logic [31:0] r, output logic [3:0] s, output int vc);
    bit got;
    got = 1'b0;
    r   = 32'd0;
    s   = 4'd0;
    vc  = -1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (resp_val) begin
        got = 1'b1;
        r   = resp_out;
        s   = resp_sat;
        vc  = cyc;
      end
    end
    @(posedge clk);
    #1;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL resp_timeout: resp_val stayed 0, expected 1 within 100 cycles");
    end
  endtask

  // One transaction: latency check, plus literal result check when given.
  task automatic vec(input string name, input logic [3:0] op, input logic [1:0] lw,
                     input logic [31:0] a, input logic [31:0] b,
                     input bit has_lit, input logic [31:0] lit_r, input logic [3:0] lit_s);
    int acc, vc;
    logic [31:0] r;
    logic [3:0]  s;
    send(op, lw, a, b, acc);
    wait_resp(r, s, vc);
    chk({name, "_latency"}, 64'(vc - acc), 64'((op == 4'd11) ? lane_w(lw) + 1 : 1));
    if (has_lit) begin
      chk({name, "_out"}, r, lit_r);
      chk({name, "_sat"}, s, lit_s);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc, acc2, vc;
    logic [31:0] r;
    logic [3:0]  s;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_rdy", req_rdy, 64'd1);
    chk("reset_resp_val", resp_val, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    vec("add_lw8",   4'd0,  2'd0, 32'h7F80_FF01, 32'h0180_0102, 1'b1, 32'h8000_0003, 4'b0000);
    vec("adds_lw8",  4'd2,  2'd0, 32'h7F80_FF01, 32'h0180_0102, 1'b1, 32'h7F80_0003, 4'b1100);
    vec("subu_lw16", 4'd5,  2'd1, 32'h0005_0010, 32'h0006_0008, 1'b1, 32'h0000_0008, 4'b1100);
    vec("sra_lw8",   4'd10, 2'd0, 32'h80F0_4001, 32'h0102_0300, 1'b1, 32'hC0FC_0801, 4'b0000);
    vec("sub_lw3",   4'd1,  2'd3, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 4'b0000);
    vec("subs_lw8",  4'd4,  2'd0, 32'h8001_7F00, 32'h01FF_8001, 1'b1, 32'h8002_7FFF, 4'b1010);
    vec("addu_lw32", 4'd3,  2'd2, 32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 32'hFFFF_FFFF, 4'b1111);
    vec("adds_lw32", 4'd2,  2'd2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b1111);
    vec("min_lw16",  4'd6,  2'd1, 32'h8000_0005, 32'h7FFF_FFFF, 1'b1, 32'h8000_FFFF, 4'b0000);
    vec("max_lw8",   4'd7,  2'd0, 32'h80FF_7F01, 32'h7F00_807F, 1'b1, 32'h7F00_7F7F, 4'b0000);
    vec("sll_lw16",  4'd8,  2'd1, 32'h0001_8001, 32'h0013_000F, 1'b1, 32'h0008_8000, 4'b0000);
    vec("srl_lw32",  4'd9,  2'd2, 32'h8000_0000, 32'h0000_001F, 1'b1, 32'h0000_0001, 4'b0000);
    vec("mul_lw8",   4'd11, 2'd0, 32'h03FF_1002, 32'h05FF_1003, 1'b1, 32'h0F01_0006, 4'b0000);
    vec("rsv12",     4'd12, 2'd2, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 32'h0000_0000, 4'b0000);
    vec("rsv15",     4'd15, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 4'b0000);
    vec("sra_lw16",  4'd10, 2'd1, 32'h8421_7000, 32'h0014_0003, 1'b0, 32'h0, 4'h0);
    vec("mul_lw32",  4'd11, 2'd2, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0, 32'h0, 4'h0);
    vec("mul_lw3",   4'd11, 2'd3, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 32'h0, 4'h0);
    vec("subs_lw16", 4'd4,  2'd1, 32'h7FFF_8000, 32'hFFFF_0001, 1'b0, 32'h0, 4'h0);

    // MUL with a stalled consumer, then a no-bubble accept on retirement.
    resp_rdy = 1'b0;
    send(4'd11, 2'd1, 32'h0003_0100, 32'h0005_0100, acc);
    wait_resp(r, s, vc);
    chk("mul16_latency", 64'(vc - acc), 64'd17);
    chk("mul16_out", r, 32'h000F_0000);
    chk("mul16_sat", s, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_resp_val", resp_val, 64'd1);
      chk("hold_resp_out", resp_out, 32'h000F_0000);
      chk("hold_req_rdy", req_rdy, 64'd0);
      @(posedge clk);
      #1;
    end
    resp_rdy = 1'b1;
    send(4'd0, 2'd0, 32'h7F80_FF01, 32'h0180_0102, acc2);
    chk("no_bubble_accept_cycle", 64'(acc2), 64'(vc + 4));
    wait_resp(r, s, vc);
    chk("b2b_add_out", r, 32'h8000_0003);
    chk("b2b_add_latency", 64'(vc - acc2), 64'd1);

    // Reset in MUL cycle 5 aborts the multiply with no response.
    send(4'd11, 2'd1, 32'h0003_0100, 32'h0005_0100, acc);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_resp_val", resp_val, 64'd0);
    chk("abort_req_rdy", req_rdy, 64'd1);
    chk("abort_resp_out", resp_out, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    vec("add_lw32_wrap", 4'd0, 2'd2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b0000);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
